// File: rtl/pmod_als_pkg.sv
// Shared constants and FSM encodings for the PMOD ALS emulator and its reader benches.
// Frame layout: leading zeros, data bits MSB first, trailing zeros.
package pmod_als_pkg;

    localparam int DEF_LEAD_ZEROS = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FRAME_LEN  = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    // Frame phase implied by a bit position within an active frame.
    function automatic logic [1:0] pos_state(input int pos, input int lead, input int dw);
        if (pos < lead) begin
            return ST_LEAD;
        end else if (pos < lead + dw) begin
            return ST_DATA;
        end else begin
            return ST_TRAIL;
        end
    endfunction

endpackage

// File: rtl/pmod_als_emu_sync.sv
// Two-flop synchroniser for an asynchronous input plus a third flop for edge detection.
// rise_o/fall_o are single-cycle pulses in the clk_i domain.
module sync_edge_det #(
    parameter logic RST_LEVEL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Flops reset to the line's idle level so reset never fabricates an edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_LEVEL;
            sync_q <= RST_LEVEL;
            prev_q <= RST_LEVEL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/pmod_als_emu.sv
// SPI responder emulating the PMOD ALS ADC frame: zeros, held light value MSB first, zeros.
// CS/SCK are synchronised into clk_i, which must run at least 4x the SCK frequency.
module pmod_als_emu
    import pmod_als_pkg::*;
#(
    parameter int               LEAD_ZEROS = DEF_LEAD_ZEROS,
    parameter int               DATA_W     = DEF_DATA_W,
    parameter int               FRAME_LEN  = DEF_FRAME_LEN,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_we_i,
    input  logic              cs_i,
    input  logic              sck_i,
    output logic              sdo_o,
    output logic              sdo_oe_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              frame_abort_o
);

    localparam int POS_W    = $clog2(FRAME_LEN);
    localparam int IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DATA_END = LEAD_ZEROS + DATA_W;

    localparam logic [POS_W-1:0] POS_MAX      = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0] POS_DATA_END = POS_W'(DATA_END);

    logic cs_rise;
    logic cs_fall;
    logic sck_fall;
    logic sck_rise_unused;

    sync_edge_det #(.RST_LEVEL(1'b1)) u_cs_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (cs_i),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge_det #(.RST_LEVEL(1'b1)) u_sck_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (sck_i),
        .rise_o  (sck_rise_unused),
        .fall_o  (sck_fall)
    );

    logic [1:0]        state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic              sdo_q, sdo_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic [IDX_W-1:0]  bit_idx;

    always_comb begin
        held_d  = data_we_i ? data_i : held_q;
        snap_d  = snap_q;
        pos_d   = pos_q;
        state_d = state_q;
        sdo_d   = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        bit_idx = '0;

        if (cs_fall) begin
            // held_d already carries a same-cycle write, so the write wins.
            state_d = ST_LEAD;
            pos_d   = '0;
            snap_d  = held_d;
        end else if (cs_rise) begin
            if (state_q != ST_IDLE) begin
                if (pos_q >= POS_DATA_END) begin
                    done_d = 1'b1;
                end else begin
                    abort_d = 1'b1;
                end
            end
            state_d = ST_IDLE;
        end else if (state_q != ST_IDLE) begin
            if (sck_fall && (pos_q != POS_MAX)) begin
                pos_d = pos_q + POS_W'(1);
            end
            state_d = pos_state(int'(pos_d), LEAD_ZEROS, DATA_W);
            bit_idx = IDX_W'(DATA_END - 1 - int'(pos_d));
            if (state_d == ST_DATA) begin
                sdo_d = snap_q[bit_idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            held_q  <= RESET_VAL;
            snap_q  <= '0;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            held_q  <= held_d;
            snap_q  <= snap_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign sdo_o         = sdo_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign sdo_oe_o      = busy_o;
    assign frame_done_o  = done_q;
    assign frame_abort_o = abort_q;

endmodule
